// File: rtl/pipeline_fifo.sv
// rtl/pipeline_fifo.sv - elastic first-word-fall-through buffer behind the last pipeline stage
//
// Purpose: absorbs the pipeline output stream so consumer back-pressure does not
// stall the stages. Same valid/ready handshake on both sides; DEPTH need not be a
// power of two. i_ready comes straight from a register, so o_ready never reaches
// i_ready combinationally.
//
// Optional feature macro: PIPELINE_FIFO_BYPASS_EN
//   When defined, an empty buffer forwards i_value/i_valid to o_value/o_valid in
//   the same cycle; a value taken by the consumer that cycle is never stored.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   i_value  in   BITS   upstream value
//   i_valid  in   1      upstream value valid
//   i_ready  out  1      buffer can accept (registered, == ~full)
//   o_value  out  BITS   head value (0 when empty, unless bypassing)
//   o_valid  out  1      head value valid
//   o_ready  in   1      consumer accepts
//   count    out  $clog2(DEPTH+1)  stored entries
//   full     out  1      count == DEPTH
//   empty    out  1      count == 0

module pipeline_fifo #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [BITS-1:0]            i_value,
  input  logic                       i_valid,
  output logic                       i_ready,
  output logic [BITS-1:0]            o_value,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;

  logic            push;      // handshake accepted on the input side
  logic            pop;       // handshake accepted on the output side
  logic            store;     // push that actually lands in storage
  logic            take;      // pop that actually consumes a stored entry
  logic [CW-1:0]   count_next;
  logic            full_next;
  logic            empty_next;

  always_comb begin
    push = i_valid & i_ready;
`ifdef PIPELINE_FIFO_BYPASS_EN
    o_valid = empty ? i_valid : 1'b1;
    o_value = empty ? i_value : mem[rp];
    pop     = o_valid & o_ready;
    // A value consumed while empty went straight through and is never written.
    store   = push & ~(empty & o_ready);
    take    = pop & ~empty;
`else
    o_valid = ~empty;
    o_value = empty ? '0 : mem[rp];
    pop     = o_valid & o_ready;
    store   = push;
    take    = pop;
`endif
  end

  always_comb begin
    count_next = count;
    if (store && !take) begin
      count_next = count + 1'b1;
    end else if (take && !store) begin
      count_next = count - 1'b1;
    end
    full_next  = (count_next == CW'(DEPTH));
    empty_next = (count_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      i_ready <= 1'b1;
    end else begin
      if (store) begin
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      end
      if (take) begin
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      end
      count   <= count_next;
      full    <= full_next;
      empty   <= empty_next;
      i_ready <= ~full_next;
    end
  end

  // Storage has no reset; a write on the reset cycle is suppressed so nothing
  // half-commits while pointers are being cleared.
  always_ff @(posedge clock) begin
    if (!reset && store) begin
      mem[wp] <= i_value;
    end
  end

endmodule

// File: tb/tb_pipeline_fifo.sv
// tb/tb_pipeline_fifo.sv - scoreboard bench for pipeline_fifo (DEPTH 8 and DEPTH 5 instances)

module tb_pipeline_fifo;

`ifdef PIPELINE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock;
  logic       reset;

  logic [7:0] a_i_value, a_o_value;
  logic       a_i_valid, a_i_ready, a_o_valid, a_o_ready, a_full, a_empty;
  logic [3:0] a_count;

  logic [7:0] b_i_value, b_o_value;
  logic       b_i_valid, b_i_ready, b_o_valid, b_o_ready, b_full, b_empty;
  logic [2:0] b_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  pipeline_fifo #(.DEPTH(8), .BITS(8)) dut_a (
    .clock(clock), .reset(reset),
    .i_value(a_i_value), .i_valid(a_i_valid), .i_ready(a_i_ready),
    .o_value(a_o_value), .o_valid(a_o_valid), .o_ready(a_o_ready),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  pipeline_fifo #(.DEPTH(5), .BITS(8)) dut_b (
    .clock(clock), .reset(reset),
    .i_value(b_i_value), .i_valid(b_i_valid), .i_ready(b_i_ready),
    .o_value(b_o_value), .o_valid(b_o_valid), .o_ready(b_o_ready),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: record accepted inputs, compare every accepted output.
  always @(negedge clock) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_i_valid && a_i_ready) qa.push_back(a_i_value);
      if (a_o_valid && a_o_ready) begin
        if (qa.size() == 0) check("a_unexpected_pop", 32'(qa.size()), 32'd1);
        else check("a_o_value", 32'(a_o_value), 32'(qa.pop_front()));
      end
      if (b_i_valid && b_i_ready) qb.push_back(b_i_value);
      if (b_o_valid && b_o_ready) begin
        if (qb.size() == 0) check("b_unexpected_pop", 32'(qb.size()), 32'd1);
        else check("b_o_value", 32'(b_o_value), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_i_value = '0; a_i_valid = 1'b0; a_o_ready = 1'b0;
    b_i_value = '0; b_i_valid = 1'b0; b_o_ready = 1'b0;

    // Reset then idle
    step();
    step();
    check("rst_count",   32'(a_count),   32'd0);
    check("rst_empty",   32'(a_empty),   32'd1);
    check("rst_full",    32'(a_full),    32'd0);
    check("rst_i_ready", 32'(a_i_ready), 32'd1);
    check("rst_o_valid", 32'(a_o_valid), 32'd0);
    check("rst_o_value", 32'(a_o_value), 32'd0);
    check("rst_b_empty", 32'(b_empty),   32'd1);
    reset = 1'b0;
    step();

    // Fill 0x01..0x08 with consumer stalled, then drain
    a_o_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      a_i_value = 8'(k);
      a_i_valid = 1'b1;
      if (k == 1) begin
        #1;
        check("latency_o_valid_same_cycle", 32'(a_o_valid), 32'(BYP));
      end
      step();
      if (k == 1) check("latency_o_valid_next", 32'(a_o_valid), 32'd1);
    end
    a_i_valid = 1'b0;
    check("fill_full",    32'(a_full),    32'd1);
    check("fill_i_ready", 32'(a_i_ready), 32'd0);
    check("fill_count",   32'(a_count),   32'd8);
    a_o_ready = 1'b1;
    repeat (8) step();
    check("drain_empty", 32'(a_empty), 32'd1);
    check("drain_count", 32'(a_count), 32'd0);

    // Streaming 0x10..0x3F with push and pop every cycle
    for (int v = 8'h10; v <= 8'h3F; v++) begin
      a_i_value = 8'(v);
      a_i_valid = 1'b1;
      step();
      check("stream_count",   32'(a_count),   BYP ? 32'd0 : 32'd1);
      check("stream_o_valid", 32'(a_o_valid), 32'd1);
    end
    a_i_valid = 1'b0;
    step();
    check("stream_end_empty", 32'(a_empty), 32'd1);

    // Full with simultaneous pop
    a_o_ready = 1'b0;
    for (int v = 8'h60; v <= 8'h67; v++) begin
      a_i_value = 8'(v);
      a_i_valid = 1'b1;
      step();
    end
    check("fp_full", 32'(a_full), 32'd1);
    a_i_value = 8'hEE;
    a_o_ready = 1'b1;
    step();
    check("fp_count_pop_only", 32'(a_count),   32'd7);
    check("fp_i_ready_back",   32'(a_i_ready), 32'd1);
    step();
    check("fp_count_push_pop", 32'(a_count), 32'd7);
    a_i_valid = 1'b0;
    for (int t = 0; t < 12 && !a_empty; t++) step();
    check("fp_drained", 32'(a_empty), 32'd1);

    // Reset mid-stream
    a_o_ready = 1'b0;
    for (int v = 8'h70; v <= 8'h73; v++) begin
      a_i_value = 8'(v);
      a_i_valid = 1'b1;
      step();
    end
    check("mr_count4", 32'(a_count), 32'd4);
    a_i_value = 8'h74;
    a_o_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_i_valid = 1'b0;
    #1;
    check("mr_count",   32'(a_count),   32'd0);
    check("mr_o_valid", 32'(a_o_valid), 32'd0);
    a_i_value = 8'h80;
    a_i_valid = 1'b1;
    step();
    a_i_value = 8'h81;
    step();
    a_i_valid = 1'b0;
    for (int t = 0; t < 6 && !a_empty; t++) step();
    check("mr_after_empty", 32'(a_empty), 32'd1);
    check("mr_sb_empty",    32'(qa.size()), 32'd0);

    // Wrap-around on DEPTH=5
    b_o_ready = 1'b0;
    for (int v = 8'h51; v <= 8'h53; v++) begin
      b_i_value = 8'(v);
      b_i_valid = 1'b1;
      step();
    end
    b_i_valid = 1'b0;
    b_o_ready = 1'b1;
    repeat (3) step();
    check("wrap_empty_after3", 32'(b_empty), 32'd1);
    b_o_ready = 1'b0;
    for (int v = 8'hA0; v <= 8'hA4; v++) begin
      b_i_value = 8'(v);
      b_i_valid = 1'b1;
      step();
    end
    b_i_valid = 1'b0;
    check("wrap_full",    32'(b_full),    32'd1);
    check("wrap_count",   32'(b_count),   32'd5);
    check("wrap_i_ready", 32'(b_i_ready), 32'd0);
    b_o_ready = 1'b1;
    repeat (5) step();
    check("wrap_drained", 32'(b_empty), 32'd1);
    check("wrap_sb_empty", 32'(qb.size()), 32'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_fifo.md
Name: pipeline_fifo

Overview:
- Elastic buffer that sits directly downstream of the pipeline's last stage and absorbs its output stream.
- Decouples pipeline throughput from consumer back-pressure, so the stages do not stall on every consumer hiccup.
- Same valid/ready protocol on both sides; first-word-fall-through; storage depth set by parameter.

Parameters:
- DEPTH, 8, number of storage entries; legal range 2..256, need not be a power of two.
- BITS, 8, width of each value.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- i_value  input  BITS  value from upstream pipeline.
- i_valid  input  1  upstream value valid.
- i_ready  output  1  buffer can accept; a transfer occurs when i_valid & i_ready.
- o_value  output  BITS  head value to consumer.
- o_valid  output  1  head value valid.
- o_ready  input  1  consumer accepts; a transfer occurs when o_valid & o_ready.
- count  output  $clog2(DEPTH+1)  number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, port reset.
- Reset values: count=0, empty=1, full=0, o_valid=0, o_value=0, i_ready=1; write and read pointers = 0. Storage array is not reset.
- Reset asserted mid-operation discards all stored entries at that edge; no partial transfer is committed on the reset cycle.
- Storage: DEPTH-entry array, write pointer wp and read pointer rp. Each pointer increments on its transfer and wraps from DEPTH-1 to 0, explicit compare, no modulo-2^n assumption.
- Push = i_valid & i_ready: mem[wp] <= i_value; wp advances.
- Pop = o_valid & o_ready: rp advances.
- count: +1 on push only, -1 on pop only, unchanged on push&pop or on neither. full and empty are registered, updated with count.
- i_ready = ~full, driven from a register only. No combinational path from o_ready to i_ready; this breaks the ready chain that enters the pipeline.
- o_valid = ~empty; o_value = mem[rp] when ~empty, else 0. First-word-fall-through.
- Latency (no bypass): a value pushed at edge N is visible on o_value/o_valid after edge N, popable at edge N+1. Minimum latency 1 cycle.
- Full: i_ready=0, so no push even with simultaneous pop. i_ready returns to 1 the cycle after the pop. Throughput when held full is 1 transfer every 2 cycles unless the consumer keeps the buffer below full.
- Empty: no pop possible; o_ready is ignored.
- Simultaneous push and pop with 0<count<DEPTH: both commit, count unchanged, order preserved.
- i_valid dropping while i_ready=0 is a protocol violation by upstream. The block does not need to handle it, but it must not corrupt pointers.
- Sustained push/pop with count between 1 and DEPTH-1 gives 1 value per cycle.

Optional Feature:
- Macro: PIPELINE_FIFO_BYPASS_EN.
- Defined:
  - when empty=1, o_valid = i_valid and o_value = i_value combinationally.
  - If o_ready=1 in that cycle, the value passes straight through: no write, count stays 0. Zero-cycle latency.
  - If o_ready=0, the value is stored normally, count becomes 1.
  - i_ready remains ~full (still registered).
  - Reset values unchanged, except o_value follows i_value while empty.
- Undefined: behaviour exactly as in Behaviour above; i_value never reaches o_value in the same cycle.

Test Plan:
- Reset then idle: after reset high for 2 cycles -> count=0, empty=1, full=0, i_ready=1, o_valid=0, o_value=0.
- DEPTH=8, o_ready=0, push 0x01..0x08 on consecutive cycles -> full=1 and i_ready=0 after the 8th edge, count=8. Then o_ready=1 for 8 cycles -> o_value sequence 0x01..0x08, then empty=1.
- Streaming: DEPTH=8, i_valid=1 and o_ready=1 every cycle, values 0x10..0x3F -> output identical order, count stays at most 1, no bubbles after the first value, 1-cycle latency (0 with PIPELINE_FIFO_BYPASS_EN and count=0 throughout).
- Wrap-around: DEPTH=5, push 3, pop 3, then push 5 values 0xA0..0xA4 while popping none -> full=1. Pop all -> 0xA0..0xA4 in order, with both pointers having wrapped.
- Full with simultaneous pop: fill to 8, hold i_valid=1 (0xEE) and o_ready=1 -> cycle 1 pops, no push, count=7. Next cycle push and pop both commit, count stays 7. 0xEE appears after the 7 older values.
- Reset mid-stream: count=4 with i_valid=1 and o_ready=1, assert reset for 1 cycle -> next cycle count=0, o_valid=0, none of the 4 old values is ever output afterwards.
